// File: rtl/ste_bus_pkg.sv
// ste_bus_pkg: shared definitions for the STE system bus arbiter.
//   owner_t / OWNER_*  : bus owner encodings (CPU, DMA, blitter)
//   arb_state_e        : arbiter FSM states
//   pick_winner()      : fixed-priority selection, DMA ahead of the blitter
package ste_bus_pkg;

  typedef logic [1:0] owner_t;

  localparam owner_t OWNER_CPU = 2'd0;
  localparam owner_t OWNER_DMA = 2'd1;
  localparam owner_t OWNER_BLT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2,
    ST_OWN   = 2'd3
  } arb_state_e;

  // DMA always beats the blitter; CPU is returned when nobody asks.
  function automatic owner_t pick_winner(input logic dma_req, input logic blt_req);
    owner_t w;
    if (dma_req) begin
      w = OWNER_DMA;
    end else if (blt_req) begin
      w = OWNER_BLT;
    end else begin
      w = OWNER_CPU;
    end
    return w;
  endfunction

endpackage

// File: rtl/ste_bus_tick_counter.sv
// ste_bus_tick_counter: saturating counter of clk_en ticks.
//   clk32, resb : clock, asynchronous active-low reset
//   clk_en      : tick qualifier
//   clr         : synchronous clear (wins over inc)
//   inc         : count this tick when clk_en is high
//   at_limit    : the counter holds TERMINAL-1 or TERMINAL, i.e. the current
//                 enabled tick is (or is past) the TERMINAL-th one
module ste_bus_tick_counter #(
  parameter int TERMINAL = 15
) (
  input  logic clk32,
  input  logic resb,
  input  logic clk_en,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CW = $clog2(TERMINAL + 1);
  localparam logic [CW-1:0] TERM_V = CW'(TERMINAL);
  localparam logic [CW-1:0] LAST_V = CW'(TERMINAL - 1);

  logic [CW-1:0] cnt_r;

  // Tick counter: clear, or count enabled ticks up to TERMINAL and hold.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (clk_en && inc && (cnt_r != TERM_V)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_limit = (cnt_r >= LAST_V);

endmodule

// File: rtl/ste_bus_arbiter.sv
// ste_bus_arbiter: arbitrates the STE system bus between the 68000 (default
// owner), the floppy/HDD DMA controller and the blitter using BR/BG/BGACK.
//   clk32, resb        : 32 MHz clock, asynchronous active-low reset
//   clk_en             : 8 MHz bus-cycle enable; every state change waits on it
//   as_n               : CPU address strobe; a grant is issued only while high
//   br_*_n / bgack_*_n : request / acknowledge from DMA and blitter
//   bg_*_n             : bus grants (registered)
//   blt_yield          : blitter must release at its next cycle boundary
//   bus_owner          : 0=CPU 1=DMA 2=blitter
//   bus_free           : CPU owns the bus and no grant is outstanding
//   grant_err          : one-clk32 pulse when a grant is withdrawn un-acknowledged
module ste_bus_arbiter
  import ste_bus_pkg::*;
#(
  parameter int GRANT_TIMEOUT = 15,
  parameter int BLT_QUANTUM   = 64,
  parameter int OWNER_W       = 2
) (
  input  logic               clk32,
  input  logic               resb,
  input  logic               clk_en,
  input  logic               as_n,
  input  logic               br_dma_n,
  input  logic               bgack_dma_n,
  input  logic               br_blt_n,
  input  logic               bgack_blt_n,
  output logic               bg_dma_n,
  output logic               bg_blt_n,
  output logic               blt_yield,
  output logic [OWNER_W-1:0] bus_owner,
  output logic               bus_free,
  output logic               grant_err
);

  arb_state_e         state_r;
  owner_t             winner_r;
  logic               bg_dma_n_r;
  logic               bg_blt_n_r;
  logic               blt_yield_r;
  logic [OWNER_W-1:0] bus_owner_r;
  logic               grant_err_r;

  logic   req_dma_s;
  logic   req_blt_s;
  owner_t arb_win_s;
  logic   win_req_s;
  logic   win_ack_s;
  logic   in_grant_s;
  logic   blt_own_s;
  logic   grant_hit_s;
  logic   quantum_hit_s;
  logic   yield_set_s;

  assign req_dma_s  = ~br_dma_n;
  assign req_blt_s  = ~br_blt_n;
  assign arb_win_s  = pick_winner(req_dma_s, req_blt_s);
  assign in_grant_s = (state_r == ST_GRANT);
  assign blt_own_s  = (state_r == ST_OWN) && (winner_r == OWNER_BLT);

  // Request/acknowledge of the latched winner only; other masters' bgack is ignored.
  always_comb begin
    win_req_s = 1'b0;
    win_ack_s = 1'b0;
    case (winner_r)
      OWNER_DMA: begin
        win_req_s = ~br_dma_n;
        win_ack_s = ~bgack_dma_n;
      end
      OWNER_BLT: begin
        win_req_s = ~br_blt_n;
        win_ack_s = ~bgack_blt_n;
      end
      default: begin
        win_req_s = 1'b0;
        win_ack_s = 1'b0;
      end
    endcase
  end

  // Yield is requested by a waiting DMA master (no pre-emption) or quantum expiry.
  always_comb begin
    yield_set_s = 1'b0;
    if (winner_r == OWNER_BLT) begin
      yield_set_s = req_dma_s || (blt_own_s && quantum_hit_s);
    end else begin
      yield_set_s = 1'b0;
    end
  end

  ste_bus_tick_counter #(.TERMINAL(GRANT_TIMEOUT)) u_grant_cnt (
    .clk32    (clk32),
    .resb     (resb),
    .clk_en   (clk_en),
    .clr      (~in_grant_s),
    .inc      (in_grant_s),
    .at_limit (grant_hit_s)
  );

  ste_bus_tick_counter #(.TERMINAL(BLT_QUANTUM)) u_quantum_cnt (
    .clk32    (clk32),
    .resb     (resb),
    .clk_en   (clk_en),
    .clr      (~blt_own_s),
    .inc      (blt_own_s),
    .at_limit (quantum_hit_s)
  );

  // Arbiter FSM with registered grant, owner, yield and error outputs.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state_r     <= ST_IDLE;
      winner_r    <= OWNER_CPU;
      bg_dma_n_r  <= 1'b1;
      bg_blt_n_r  <= 1'b1;
      blt_yield_r <= 1'b0;
      bus_owner_r <= '0;
      grant_err_r <= 1'b0;
    end else begin
      grant_err_r <= 1'b0;
      if (clk_en) begin
        case (state_r)
          ST_IDLE: begin
            blt_yield_r <= 1'b0;
            if (req_dma_s || req_blt_s) begin
              state_r <= ST_ARB;
            end
          end
          ST_ARB: begin
            blt_yield_r <= 1'b0;
            if (!(req_dma_s || req_blt_s)) begin
              state_r <= ST_IDLE;
            end else if (as_n) begin
              // Winner is frozen here until the arbiter returns to IDLE.
              winner_r   <= arb_win_s;
              bg_dma_n_r <= (arb_win_s != OWNER_DMA);
              bg_blt_n_r <= (arb_win_s != OWNER_BLT);
              state_r    <= ST_GRANT;
            end
          end
          ST_GRANT: begin
            if (win_ack_s) begin
              bg_dma_n_r  <= 1'b1;
              bg_blt_n_r  <= 1'b1;
              bus_owner_r <= OWNER_W'(winner_r);
              blt_yield_r <= blt_yield_r | yield_set_s;
              state_r     <= ST_OWN;
            end else if (!win_req_s) begin
              bg_dma_n_r  <= 1'b1;
              bg_blt_n_r  <= 1'b1;
              blt_yield_r <= 1'b0;
              state_r     <= ST_IDLE;
            end else if (grant_hit_s) begin
              bg_dma_n_r  <= 1'b1;
              bg_blt_n_r  <= 1'b1;
              blt_yield_r <= 1'b0;
              grant_err_r <= 1'b1;
              state_r     <= ST_IDLE;
            end else begin
              blt_yield_r <= blt_yield_r | yield_set_s;
            end
          end
          ST_OWN: begin
            // Release is handled before any new request; OWN always exits via IDLE.
            if (!win_ack_s) begin
              bus_owner_r <= '0;
              blt_yield_r <= 1'b0;
              state_r     <= ST_IDLE;
            end else begin
              blt_yield_r <= blt_yield_r | yield_set_s;
            end
          end
          default: begin
            bg_dma_n_r  <= 1'b1;
            bg_blt_n_r  <= 1'b1;
            blt_yield_r <= 1'b0;
            bus_owner_r <= '0;
            state_r     <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bg_dma_n  = bg_dma_n_r;
  assign bg_blt_n  = bg_blt_n_r;
  assign blt_yield = blt_yield_r;
  assign bus_owner = bus_owner_r;
  assign grant_err = grant_err_r;
  assign bus_free  = (state_r == ST_IDLE) || (state_r == ST_ARB);

endmodule

// File: tb/tb_ste_bus_arbiter.sv
module tb_ste_bus_arbiter;

  typedef struct {
    logic       as_n;
    logic       br_dma_n;
    logic       bgack_dma_n;
    logic       br_blt_n;
    logic       bgack_blt_n;
    logic       bg_dma_n;
    logic       bg_blt_n;
    logic       yield;
    logic [1:0] owner;
    logic       free;
    logic       err;
  } vec_t;

  typedef struct {
    logic       bg_dma_n;
    logic       bg_blt_n;
    logic       yield;
    logic [1:0] owner;
    logic       free;
    logic       err;
  } exp_t;

  logic       clk32 = 1'b0;
  logic       resb = 1'b0;
  logic       clk_en = 1'b0;
  logic [1:0] en_cnt = 2'd0;
  logic       as_n = 1'b1;
  logic       br_dma_n = 1'b1;
  logic       bgack_dma_n = 1'b1;
  logic       br_blt_n = 1'b1;
  logic       bgack_blt_n = 1'b1;
  logic       bg_dma_n;
  logic       bg_blt_n;
  logic       blt_yield;
  logic [1:0] bus_owner;
  logic       bus_free;
  logic       grant_err;

  int   total = 0;
  int   bad = 0;
  int   err_pulses = 0;
  vec_t vecs[$];
  exp_t sb_q[$];

  ste_bus_arbiter #(.GRANT_TIMEOUT(15), .BLT_QUANTUM(64), .OWNER_W(2)) dut (
    .clk32       (clk32),
    .resb        (resb),
    .clk_en      (clk_en),
    .as_n        (as_n),
    .br_dma_n    (br_dma_n),
    .bgack_dma_n (bgack_dma_n),
    .br_blt_n    (br_blt_n),
    .bgack_blt_n (bgack_blt_n),
    .bg_dma_n    (bg_dma_n),
    .bg_blt_n    (bg_blt_n),
    .blt_yield   (blt_yield),
    .bus_owner   (bus_owner),
    .bus_free    (bus_free),
    .grant_err   (grant_err)
  );

  always #5 clk32 = ~clk32;

  // 8 MHz enable: one clk32 cycle in four.
  always @(negedge clk32) begin
    en_cnt <= en_cnt + 2'd1;
    clk_en <= (en_cnt == 2'd3);
  end

  // Count clk32 cycles during which grant_err is high.
  always @(negedge clk32) begin
    if (grant_err) err_pulses <= err_pulses + 1;
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance to 1 ns after the next clk32 edge with clk_en high.
  task automatic tick();
    int guard;
    guard = 0;
    @(posedge clk32);
    while (clk_en !== 1'b1 && guard < 16) begin
      @(posedge clk32);
      guard++;
    end
    if (guard >= 16) chk("clk_en_seen", 8'd0, 8'd1);
    #1;
  endtask

  task automatic drive(input logic a, input logic brd, input logic bkd, input logic brb, input logic bkb);
    as_n = a; br_dma_n = brd; bgack_dma_n = bkd; br_blt_n = brb; bgack_blt_n = bkb;
  endtask

  function automatic vec_t v(input logic a, input logic brd, input logic bkd, input logic brb,
                             input logic bkb, input logic bgd, input logic bgb, input logic y,
                             input logic [1:0] own, input logic fr, input logic er);
    vec_t r;
    r = '{as_n: a, br_dma_n: brd, bgack_dma_n: bkd, br_blt_n: brb, bgack_blt_n: bkb,
          bg_dma_n: bgd, bg_blt_n: bgb, yield: y, owner: own, free: fr, err: er};
    return r;
  endfunction

  task automatic check_exp(input string tag, input exp_t e);
    chk($sformatf("%s bg_dma_n", tag), {7'd0, bg_dma_n}, {7'd0, e.bg_dma_n});
    chk($sformatf("%s bg_blt_n", tag), {7'd0, bg_blt_n}, {7'd0, e.bg_blt_n});
    chk($sformatf("%s blt_yield", tag), {7'd0, blt_yield}, {7'd0, e.yield});
    chk($sformatf("%s bus_owner", tag), {6'd0, bus_owner}, {6'd0, e.owner});
    chk($sformatf("%s bus_free", tag), {7'd0, bus_free}, {7'd0, e.free});
    chk($sformatf("%s grant_err", tag), {7'd0, grant_err}, {7'd0, e.err});
  endtask

  // Drive one vector, queue its expectation, tick, then pop and compare.
  task automatic run_vec(input vec_t x, input string tag);
    exp_t e;
    drive(x.as_n, x.br_dma_n, x.bgack_dma_n, x.br_blt_n, x.bgack_blt_n);
    e = '{bg_dma_n: x.bg_dma_n, bg_blt_n: x.bg_blt_n, yield: x.yield,
          owner: x.owner, free: x.free, err: x.err};
    sb_q.push_back(e);
    tick();
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard"}, 8'd0, 8'd1);
    end else begin
      e = sb_q.pop_front();
      check_exp(tag, e);
    end
  endtask

  initial begin
    int snap;
    //          as brd bkd brb bkb | bgd bgb y own free err
    // DMA only
    vecs.push_back(v(1, 0, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(1, 0, 1, 1, 1,  0, 1, 0, 2'd0, 0, 0));
    vecs.push_back(v(1, 0, 0, 1, 1,  1, 1, 0, 2'd1, 0, 0));
    vecs.push_back(v(1, 0, 0, 1, 1,  1, 1, 0, 2'd1, 0, 0));
    vecs.push_back(v(1, 1, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(1, 1, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));
    // CPU busy for 4 ticks
    vecs.push_back(v(0, 0, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(1, 0, 1, 1, 1,  0, 1, 0, 2'd0, 0, 0));
    vecs.push_back(v(1, 0, 0, 1, 1,  1, 1, 0, 2'd1, 0, 0));
    vecs.push_back(v(1, 1, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));
    // Contention: DMA first, blitter after passing through IDLE
    vecs.push_back(v(1, 0, 1, 0, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(1, 0, 1, 0, 1,  0, 1, 0, 2'd0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 1,  1, 1, 0, 2'd1, 0, 0));
    vecs.push_back(v(1, 1, 1, 0, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(1, 1, 1, 0, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(1, 1, 1, 0, 1,  1, 0, 0, 2'd0, 0, 0));
    vecs.push_back(v(1, 1, 1, 0, 0,  1, 1, 0, 2'd2, 0, 0));
    vecs.push_back(v(1, 1, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));
    // Stray DMA bgack while the blitter is granted is ignored
    vecs.push_back(v(1, 1, 0, 0, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(1, 1, 0, 0, 1,  1, 0, 0, 2'd0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 1,  1, 0, 0, 2'd0, 0, 0));
    vecs.push_back(v(1, 1, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));
    // Release and new request on the same tick: release first, then IDLE->ARB
    vecs.push_back(v(1, 0, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(1, 0, 1, 1, 1,  0, 1, 0, 2'd0, 0, 0));
    vecs.push_back(v(1, 0, 0, 1, 1,  1, 1, 0, 2'd1, 0, 0));
    vecs.push_back(v(1, 1, 1, 0, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(1, 1, 1, 0, 1,  1, 1, 0, 2'd0, 1, 0));
    vecs.push_back(v(1, 1, 1, 0, 1,  1, 0, 0, 2'd0, 0, 0));
    vecs.push_back(v(1, 1, 1, 1, 1,  1, 1, 0, 2'd0, 1, 0));

    // Reset state
    repeat (3) @(posedge clk32);
    #1;
    check_exp("reset", '{bg_dma_n: 1'b1, bg_blt_n: 1'b1, yield: 1'b0, owner: 2'd0, free: 1'b1, err: 1'b0});
    @(negedge clk32);
    resb = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Quantum: yield exactly at the 64th owned tick, held afterwards
    drive(1, 1, 1, 0, 1); tick(); tick();
    drive(1, 1, 1, 0, 0); tick();
    chk("quantum owner", {6'd0, bus_owner}, 8'd2);
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 63) chk("quantum yield@63", {7'd0, blt_yield}, 8'd0);
      if (k == 64) chk("quantum yield@64", {7'd0, blt_yield}, 8'd1);
    end
    tick(); tick();
    chk("quantum yield held", {7'd0, blt_yield}, 8'd1);
    drive(1, 1, 1, 1, 1); tick();
    chk("quantum release yield", {7'd0, blt_yield}, 8'd0);
    chk("quantum release free", {7'd0, bus_free}, 8'd1);

    // DMA request at tick 10 of blitter ownership: yield, no pre-emption
    drive(1, 1, 1, 0, 1); tick(); tick();
    drive(1, 1, 1, 0, 0); tick();
    for (int k = 1; k <= 9; k++) tick();
    chk("dmayield yield@9", {7'd0, blt_yield}, 8'd0);
    drive(1, 0, 1, 0, 0); tick();
    chk("dmayield yield@10", {7'd0, blt_yield}, 8'd1);
    chk("dmayield owner", {6'd0, bus_owner}, 8'd2);
    chk("dmayield bg_dma_n", {7'd0, bg_dma_n}, 8'd1);
    drive(1, 0, 1, 1, 1); tick();
    chk("dmayield rel yield", {7'd0, blt_yield}, 8'd0);
    chk("dmayield rel owner", {6'd0, bus_owner}, 8'd0);
    tick(); tick();
    chk("dmayield dma granted", {7'd0, bg_dma_n}, 8'd0);
    drive(1, 1, 1, 1, 1); tick();
    chk("dmayield dma withdraw", {7'd0, bg_dma_n}, 8'd1);

    // Grant timeout: 15 ticks un-acknowledged, single grant_err pulse, re-win
    snap = err_pulses;
    drive(1, 1, 1, 0, 1); tick(); tick();
    chk("timeout granted", {7'd0, bg_blt_n}, 8'd0);
    for (int k = 1; k <= 14; k++) tick();
    chk("timeout bg@14", {7'd0, bg_blt_n}, 8'd0);
    chk("timeout err@14", {7'd0, grant_err}, 8'd0);
    tick();
    chk("timeout bg@15", {7'd0, bg_blt_n}, 8'd1);
    chk("timeout err@15", {7'd0, grant_err}, 8'd1);
    chk("timeout free", {7'd0, bus_free}, 8'd1);
    @(posedge clk32); #1;
    chk("timeout err width", {7'd0, grant_err}, 8'd0);
    tick();
    chk("timeout rearb bg", {7'd0, bg_blt_n}, 8'd1);
    tick();
    chk("timeout rewin bg", {7'd0, bg_blt_n}, 8'd0);
    drive(1, 1, 1, 1, 1); tick();
    chk("timeout err count", err_pulses[7:0] - snap[7:0], 8'd1);

    // Asynchronous reset in the middle of a blitter tenure
    drive(1, 1, 1, 0, 1); tick(); tick();
    drive(1, 1, 1, 0, 0); tick();
    drive(1, 0, 1, 0, 0); tick();
    chk("areset pre yield", {7'd0, blt_yield}, 8'd1);
    chk("areset pre owner", {6'd0, bus_owner}, 8'd2);
    #2 resb = 1'b0;
    #1;
    check_exp("areset", '{bg_dma_n: 1'b1, bg_blt_n: 1'b1, yield: 1'b0, owner: 2'd0, free: 1'b1, err: 1'b0});
    drive(1, 1, 1, 1, 1);
    @(negedge clk32);
    resb = 1'b1;
    tick();
    chk("areset post free", {7'd0, bus_free}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
